// File: rtl/byte_pair_capture.sv
// -----------------------------------------------------------------------------
// byte_pair_capture
//
// Captures the next two bytes strobed in after a Start_i request and presents
// them as a high/low pair. The order of the two bytes is chosen by MSBFirst_i,
// sampled on the cycle the second byte arrives. H_o/L_o change together on the
// commit edge only, and Done_o pulses for the one cycle in which the new pair
// first becomes visible.
//
// Optional feature (macro BYTE_PAIR_CAPTURE_TIMEOUT_EN):
//   Adds Timeout_i/Timeout_o and an inactivity counter that aborts a capture
//   which stalls for Timeout_i cycles. Timeout_i = 0 disables the abort.
//
// Ports
//   Clk_i        in   1    clock, rising edge
//   Reset_n_i    in   1    synchronous active-low reset
//   Start_i      in   1    request capture of the next two bytes
//   Byte_i       in   8    incoming byte
//   ByteValid_i  in   1    one-cycle strobe qualifying Byte_i
//   MSBFirst_i   in   1    1: first byte is high byte, 0: first byte is low
//   Timeout_i    in   TW   inactivity limit in cycles (macro only)
//   Timeout_o    out  1    one-cycle abort pulse (macro only)
//   Busy_o       out  1    capture in progress
//   Done_o       out  1    one-cycle pulse, new pair on H_o/L_o
//   H_o, L_o     out  8    captured high/low byte
//
// State table
//   IDLE   | waiting for Start_i, strobes ignored
//   FIRST  | waiting for first byte
//   SECOND | first byte held in temp, waiting for second byte
// -----------------------------------------------------------------------------
module byte_pair_capture #(
    parameter int TimeoutWidth = 16
) (
    input  logic                    Clk_i,
    input  logic                    Reset_n_i,
    input  logic                    Start_i,
    input  logic [7:0]              Byte_i,
    input  logic                    ByteValid_i,
    input  logic                    MSBFirst_i,
`ifdef BYTE_PAIR_CAPTURE_TIMEOUT_EN
    input  logic [TimeoutWidth-1:0] Timeout_i,
    output logic                    Timeout_o,
`endif
    output logic                    Busy_o,
    output logic                    Done_o,
    output logic [7:0]              H_o,
    output logic [7:0]              L_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] temp_q, temp_d;
    logic [7:0] h_q, h_d;
    logic [7:0] l_q, l_d;
    logic       done_q, done_d;
    logic       timeout_hit;

`ifdef BYTE_PAIR_CAPTURE_TIMEOUT_EN
    logic [TimeoutWidth-1:0] cnt_q, cnt_d;
    logic [TimeoutWidth-1:0] cnt_inc;
    logic                    timeout_q;

    assign cnt_inc = cnt_q + 1'b1;

    // Expiry is decided one cycle early so the registered Timeout_o lands on
    // the edge where the count reaches Timeout_i. A strobe in that same cycle
    // takes priority and the capture continues.
    assign timeout_hit = (state_q != IDLE) && !ByteValid_i &&
                         (Timeout_i != '0) && (cnt_inc == Timeout_i);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (ByteValid_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_hit;
        end
    end

    assign Timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Start_i) begin
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (ByteValid_i) begin
                    state_d = SECOND;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            SECOND: begin
                if (ByteValid_i || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: temp on first byte, pair and Done on second byte.
    always_comb begin
        temp_d = temp_q;
        h_d    = h_q;
        l_d    = l_q;
        done_d = 1'b0;
        if (state_q == FIRST && ByteValid_i) begin
            temp_d = Byte_i;
        end
        if (state_q == SECOND && ByteValid_i) begin
            done_d = 1'b1;
            if (MSBFirst_i) begin
                h_d = temp_q;
                l_d = Byte_i;
            end else begin
                h_d = Byte_i;
                l_d = temp_q;
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            temp_q <= 8'h00;
            h_q    <= 8'h00;
            l_q    <= 8'h00;
            done_q <= 1'b0;
        end else begin
            temp_q <= temp_d;
            h_q    <= h_d;
            l_q    <= l_d;
            done_q <= done_d;
        end
    end

    // Output decode
    always_comb begin
        Busy_o = (state_q == FIRST) || (state_q == SECOND);
        Done_o = done_q;
        H_o    = h_q;
        L_o    = l_q;
    end

endmodule

// File: tb/tb_byte_pair_capture.sv
module tb_byte_pair_capture;

    logic       Clk_i;
    logic       Reset_n_i;
    logic       Start_i;
    logic [7:0] Byte_i;
    logic       ByteValid_i;
    logic       MSBFirst_i;
    logic       Busy_o;
    logic       Done_o;
    logic [7:0] H_o;
    logic [7:0] L_o;
`ifdef BYTE_PAIR_CAPTURE_TIMEOUT_EN
    logic [15:0] Timeout_i;
    logic        Timeout_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: how many bytes of the pending pair are still owed
    // (0 = not capturing), the first byte held so far, and the published pair.
    int         m_owed;
    logic [7:0] m_first;
    logic [7:0] m_h;
    logic [7:0] m_l;
    logic       m_done;

    byte_pair_capture #(.TimeoutWidth(16)) dut (
        .Clk_i       (Clk_i),
        .Reset_n_i   (Reset_n_i),
        .Start_i     (Start_i),
        .Byte_i      (Byte_i),
        .ByteValid_i (ByteValid_i),
        .MSBFirst_i  (MSBFirst_i),
`ifdef BYTE_PAIR_CAPTURE_TIMEOUT_EN
        .Timeout_i   (Timeout_i),
        .Timeout_o   (Timeout_o),
`endif
        .Busy_o      (Busy_o),
        .Done_o      (Done_o),
        .H_o         (H_o),
        .L_o         (L_o)
    );

    initial begin
        Clk_i = 1'b0;
        forever #5 Clk_i = ~Clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs, let the clock edge happen, advance the model,
    // and return #1 after the edge so outputs can be sampled.
    task automatic drive_cycle(input logic rst_n, input logic start, input logic bv,
                               input logic [7:0] b, input logic msb);
        Reset_n_i   = rst_n;
        Start_i     = start;
        ByteValid_i = bv;
        Byte_i      = b;
        MSBFirst_i  = msb;
        @(posedge Clk_i);
        m_done = 1'b0;
        if (!rst_n) begin
            m_owed = 0; m_first = 8'h00; m_h = 8'h00; m_l = 8'h00;
        end else if (m_owed == 0) begin
            if (start) m_owed = 2;
        end else if (bv) begin
            if (m_owed == 2) begin
                m_first = b;
                m_owed  = 1;
            end else begin
                {m_h, m_l} = msb ? {m_first, b} : {b, m_first};
                m_done = 1'b1;
                m_owed = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
        vectors++; if (Busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", Busy_o); end
        vectors++; if (Done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", Done_o); end
        vectors++; if (H_o !== 8'h00) begin miscompares++; $display("FAIL reset_h got %h want 00", H_o); end
        vectors++; if (L_o !== 8'h00) begin miscompares++; $display("FAIL reset_l got %h want 00", L_o); end
`ifdef BYTE_PAIR_CAPTURE_TIMEOUT_EN
        vectors++; if (Timeout_o !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %b want 0", Timeout_o); end
`endif
    endtask

    task automatic test_msb_first();
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (Busy_o !== 1'b1) begin miscompares++; $display("FAIL msb_busy_start got %b want 1", Busy_o); end
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h12, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'hEE, 1'b1);
        vectors++; if (Done_o !== 1'b0) begin miscompares++; $display("FAIL msb_no_early_done got %b want 0", Done_o); end
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h34, 1'b1);
        vectors++; if (Done_o !== 1'b1) begin miscompares++; $display("FAIL msb_done got %b want 1", Done_o); end
        vectors++; if (H_o !== 8'h12 || L_o !== 8'h34) begin miscompares++; $display("FAIL msb_pair got %h%h want 1234", H_o, L_o); end
        vectors++; if (Busy_o !== 1'b0) begin miscompares++; $display("FAIL msb_busy_after got %b want 0", Busy_o); end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        vectors++; if (Done_o !== 1'b0) begin miscompares++; $display("FAIL msb_done_width got %b want 0", Done_o); end
    endtask

    task automatic test_lsb_first();
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'hAB, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        vectors++; if (H_o !== 8'h12 || L_o !== 8'h34) begin miscompares++; $display("FAIL lsb_hold got %h%h want 1234", H_o, L_o); end
        drive_cycle(1'b1, 1'b0, 1'b1, 8'hCD, 1'b0);
        vectors++; if (H_o !== 8'hCD || L_o !== 8'hAB || Done_o !== 1'b1) begin
            miscompares++; $display("FAIL lsb_pair got %h%h done %b want CDAB done 1", H_o, L_o, Done_o);
        end
    endtask

    task automatic test_coincident();
        drive_cycle(1'b1, 1'b1, 1'b1, 8'h99, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        vectors++; if (Busy_o !== 1'b1) begin miscompares++; $display("FAIL coin_start_in_second got busy %b want 1", Busy_o); end
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h66, 1'b1);
        vectors++; if (H_o !== 8'h55 || L_o !== 8'h66) begin miscompares++; $display("FAIL coin_pair got %h%h want 5566", H_o, L_o); end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        vectors++; if (Busy_o !== 1'b0 || Done_o !== 1'b0) begin
            miscompares++; $display("FAIL coin_idle got busy %b done %b want 0 0", Busy_o, Done_o);
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h88, 1'b1);
        vectors++; if (H_o !== 8'h00 || L_o !== 8'h00 || Busy_o !== 1'b0 || Done_o !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_clear got %h%h busy %b done %b want 0000 0 0", H_o, L_o, Busy_o, Done_o);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h88, 1'b1);
        vectors++; if (Done_o !== 1'b0 || Busy_o !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_discard got busy %b done %b want 0 0", Busy_o, Done_o);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h01, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h02, 1'b1);
        vectors++; if (H_o !== 8'h01 || L_o !== 8'h02 || Done_o !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_pair got %h%h done %b want 0102 done 1", H_o, L_o, Done_o);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        vectors++; if (Done_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_single_done got %b want 0", Done_o); end
    endtask

    // Minimum latency of three edges, and a restart in the Done cycle.
    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            logic [7:0] b1, b2;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
            vectors++; if (Busy_o !== 1'b1 || Done_o !== 1'b0) begin
                miscompares++; $display("FAIL b2b_start[%0d] got busy %b done %b want 1 0", n, Busy_o, Done_o);
            end
            drive_cycle(1'b1, 1'b0, 1'b1, b1, 1'b0);
            drive_cycle(1'b1, 1'b0, 1'b1, b2, 1'b0);
            vectors++; if (Done_o !== 1'b1 || H_o !== b2 || L_o !== b1) begin
                miscompares++; $display("FAIL b2b_pair[%0d] got %h%h done %b want %h%h done 1", n, H_o, L_o, Done_o, b2, b1);
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            logic rst_n, start, bv, msb;
            rst_n = ($urandom_range(0, 63) != 0);
            start = ($urandom_range(0, 3) == 0);
            bv    = $urandom_range(0, 1) == 1;
            msb   = $urandom_range(0, 1) == 1;
            drive_cycle(rst_n, start, bv, 8'($urandom), msb);
            vectors++;
            if (Busy_o !== (m_owed != 0) || Done_o !== m_done || H_o !== m_h || L_o !== m_l) begin
                miscompares++;
                $display("FAIL random[%0d] got busy %b done %b pair %h%h want busy %b done %b pair %h%h",
                         i, Busy_o, Done_o, H_o, L_o, (m_owed != 0), m_done, m_h, m_l);
            end
        end
    endtask

`ifdef BYTE_PAIR_CAPTURE_TIMEOUT_EN
    task automatic test_timeout();
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h21, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h43, 1'b1);
        Timeout_i = 16'd5;
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h9A, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            vectors++; if (Timeout_o !== 1'b0 || Busy_o !== 1'b1) begin
                miscompares++; $display("FAIL to_wait[%0d] got to %b busy %b want 0 1", k, Timeout_o, Busy_o);
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        vectors++; if (Timeout_o !== 1'b1 || Busy_o !== 1'b0 || Done_o !== 1'b0 || H_o !== 8'h21 || L_o !== 8'h43) begin
            miscompares++; $display("FAIL to_expire got to %b busy %b done %b pair %h%h want 1 0 0 2143",
                                    Timeout_o, Busy_o, Done_o, H_o, L_o);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        vectors++; if (Timeout_o !== 1'b0) begin miscompares++; $display("FAIL to_pulse_width got %b want 0", Timeout_o); end
        // Strobe on the expiry cycle wins.
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h3C, 1'b1);
        for (int k = 1; k <= 4; k++) drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 8'hC3, 1'b1);
        vectors++; if (Timeout_o !== 1'b0 || Done_o !== 1'b1 || H_o !== 8'h3C || L_o !== 8'hC3) begin
            miscompares++; $display("FAIL to_race got to %b done %b pair %h%h want 0 1 3CC3", Timeout_o, Done_o, H_o, L_o);
        end
        Timeout_i = 16'd0;
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask
`endif

    initial begin
        Reset_n_i = 1'b0; Start_i = 1'b0; Byte_i = 8'h00; ByteValid_i = 1'b0; MSBFirst_i = 1'b0;
        m_owed = 0; m_first = 8'h00; m_h = 8'h00; m_l = 8'h00; m_done = 1'b0;
`ifdef BYTE_PAIR_CAPTURE_TIMEOUT_EN
        Timeout_i = 16'd0;
`endif
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_coincident();
        test_reset_mid();
        test_back_to_back();
`ifdef BYTE_PAIR_CAPTURE_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
